load_store_unit: RTL and testbench

Multi-cycle data-memory access stage directly downstream of the ALU; consumes the ALU result as the effective address for RISC-V loads and stores. Drives a req/ready + rvalid data-memory port with byte-lane masks, aligns and sign/zero-extends load data for writeback, and stalls the core via o_busy while an access is outstanding. Flags misaligned, illegal-width and timed-out accesses.

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store stage: drives the data-memory port, aligns and extends load data.
// It stalls the core while an access is outstanding and reports access faults.
module load_store_unit #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic [1:0]  o_fault_code,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t        state, state_n;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [2:0]    f3_q;
  logic          st_q;
  logic [1:0]    code_q;
  logic [CW-1:0] cnt;

  logic          illegal, misal, tmo_hit;
  logic [1:0]    off;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [31:0]   ld_data;
  logic [3:0]    mask;
  logic [31:0]   wd;

  assign off     = addr_q[1:0];
  assign tmo_hit = (cnt == CW'(TIMEOUT_CYC - 1));
  assign misal   = ((i_funct3[1:0] == 2'b01) & i_addr[0])
                 | ((i_funct3[1:0] == 2'b10) & (|i_addr[1:0]));

  always_comb begin
    illegal = 1'b1;
    case (i_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = i_is_store;
      default:                illegal = 1'b1;
    endcase
  end

  // f3_q[2] selects zero-extension for BU/HU
  always_comb begin
    lb = i_mem_rdata[{off, 3'b000} +: 8];
    lh = off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_data = {{24{~f3_q[2] & lb[7]}}, lb};
      2'b01:   ld_data = {{16{~f3_q[2] & lh[15]}}, lh};
      default: ld_data = i_mem_rdata;
    endcase
  end

  always_comb begin
    mask = 4'b1111;
    wd   = wdata_q;
    if (st_q) begin
      case (f3_q[1:0])
        2'b00: begin
          mask = 4'b0001 << off;
          wd   = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mask = off[1] ? 4'b1100 : 4'b0011;
          wd   = {2{wdata_q[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (i_valid) state_n = (illegal | misal) ? DONE : REQ;
      REQ: begin
        if (i_mem_ready)  state_n = st_q ? DONE : WAIT;
        else if (tmo_hit) state_n = DONE;
      end
      WAIT: if (i_mem_rvalid | tmo_hit) state_n = DONE;
      DONE: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      code_q  <= 2'b00;
      cnt     <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (i_valid) begin
          addr_q  <= i_addr;
          wdata_q <= i_wdata;
          f3_q    <= i_funct3;
          st_q    <= i_is_store;
          cnt     <= '0;
          code_q  <= illegal ? 2'b11 : (misal ? 2'b01 : 2'b00);
          if ((illegal | misal) & ~i_is_store) rdata_q <= '0;
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (!i_mem_ready && tmo_hit) begin
            code_q <= 2'b10;
            if (!st_q) rdata_q <= '0;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (i_mem_rvalid) begin
            rdata_q <= ld_data;
          end else if (tmo_hit) begin
            code_q  <= 2'b10;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = ((state == IDLE) & i_valid) | (state == REQ)
                      | (state == WAIT);
  assign o_done       = (state == DONE);
  assign o_fault      = o_done & (code_q != 2'b00);
  assign o_fault_code = o_done ? code_q : 2'b00;
  assign o_rdata      = rdata_q;
  assign o_mem_req    = (state == REQ);
  assign o_mem_we     = o_mem_req & st_q;
  assign o_mem_addr   = {addr_q[31:2], 2'b00};
  assign o_mem_wdata  = o_mem_req ? wd : 32'h0;
  assign o_mem_mask   = o_mem_req ? mask : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
// Each vector drives one access; a tiny memory model answers.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_fault;
  logic [1:0]  o_fault_code;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  load_store_unit #(.TIMEOUT_CYC(16)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_is_store   (i_is_store),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rdata      (o_rdata),
    .o_fault      (o_fault),
    .o_fault_code (o_fault_code),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_mask   (o_mem_mask),
    .i_mem_ready  (i_mem_ready),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdy_dly;
    int          rv_dly;
    int          exp_cyc;
    logic [1:0]  exp_code;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mwd;
    logic [31:0] exp_maddr;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", name, act, exp);
    else
      passed++;
  endtask

  function automatic vec_t mk(
    input logic st, input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] rdata,
    input int rdy_dly, input int rv_dly, input int exp_cyc,
    input logic [1:0] exp_code, input logic [3:0] exp_mask,
    input logic [31:0] exp_mwd, input logic [31:0] exp_maddr,
    input logic chk_rd, input logic [31:0] exp_rd);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.rdy_dly = rdy_dly; v.rv_dly = rv_dly;
    v.exp_cyc = exp_cyc; v.exp_code = exp_code;
    v.exp_mask = exp_mask; v.exp_mwd = exp_mwd;
    v.exp_maddr = exp_maddr; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int done_c = -1;
    int hs = -1;
    int reqn = 0;
    logic any_req = 1'b0;
    logic exp_req;
    logic [3:0]  m_mask = '0;
    logic [31:0] m_addr = '0, m_wd = '0;
    logic m_we = 1'b0;
    logic d_fault = 1'b0, d_busy = 1'b1, d_req = 1'b1;
    logic [1:0] d_code = '0;
    logic [31:0] d_rd = '0;
    string tag;
    tag = $sformatf("v%0d", idx);
    exp_req = (v.exp_code == 2'b00) || (v.exp_code == 2'b10);
    i_is_store  = v.st;
    i_funct3    = v.f3;
    i_addr      = v.addr;
    i_wdata     = v.wdata;
    i_mem_rdata = v.rdata;
    i_valid     = 1'b1;
    for (int c = 0; c < 40; c++) begin
      i_mem_ready  = 1'b0;
      i_mem_rvalid = 1'b0;
      #1;
      if (o_mem_req) begin
        any_req = 1'b1;
        m_mask = o_mem_mask; m_addr = o_mem_addr;
        m_wd = o_mem_wdata; m_we = o_mem_we;
        if (reqn == v.rdy_dly) begin
          i_mem_ready = 1'b1;
          hs = c;
        end
        reqn++;
      end else if (hs >= 0 && !v.st && (c - hs) == v.rv_dly) begin
        i_mem_rvalid = 1'b1;
      end
      #1;
      if (c == 0) chk({tag, " busy0"}, 32'(o_busy), 32'd1);
      if (o_done) begin
        done_c = c;
        d_fault = o_fault; d_code = o_fault_code; d_rd = o_rdata;
        d_busy = o_busy; d_req = o_mem_req;
        break;
      end
      @(posedge i_clk); #1;
    end
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    chk({tag, " done_cyc"}, 32'(done_c), 32'(v.exp_cyc));
    if (done_c >= 0) begin
      chk({tag, " code"}, 32'(d_code), 32'(v.exp_code));
      chk({tag, " fault"}, 32'(d_fault), 32'(v.exp_code != 2'b00));
      chk({tag, " busy_done"}, 32'(d_busy), 32'd0);
      chk({tag, " req_done"}, 32'(d_req), 32'd0);
      if (v.chk_rd) chk({tag, " rdata"}, d_rd, v.exp_rd);
    end
    chk({tag, " any_req"}, 32'(any_req), 32'(exp_req));
    if (exp_req) begin
      chk({tag, " mask"}, 32'(m_mask), 32'(v.exp_mask));
      chk({tag, " maddr"}, m_addr, v.exp_maddr);
      chk({tag, " we"}, 32'(m_we), 32'(v.st));
      if (v.st) chk({tag, " mwdata"}, m_wd, v.exp_mwd);
    end
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    chk({tag, " done_after"}, 32'(o_done), 32'd0);
  endtask

  vec_t vt[15];

  initial begin
    vt[0]  = mk(1, 3'b010, 32'h1000, 32'hDEADBEEF, 0, 0, 0, 2,
                2'b00, 4'b1111, 32'hDEADBEEF, 32'h1000, 1, 32'h0);
    vt[1]  = mk(1, 3'b000, 32'h1003, 32'h000000A5, 0, 0, 0, 2,
                2'b00, 4'b1000, 32'hA5A5A5A5, 32'h1000, 1, 32'h0);
    vt[2]  = mk(1, 3'b001, 32'h2002, 32'h1234BEEF, 0, 2, 0, 4,
                2'b00, 4'b1100, 32'hBEEFBEEF, 32'h2000, 0, 32'h0);
    vt[3]  = mk(0, 3'b000, 32'h2002, 0, 32'h0080FF00, 0, 2, 4,
                2'b00, 4'b1111, 0, 32'h2000, 1, 32'hFFFFFF80);
    vt[4]  = mk(0, 3'b100, 32'h2002, 0, 32'h0080FF00, 0, 2, 4,
                2'b00, 4'b1111, 0, 32'h2000, 1, 32'h00000080);
    vt[5]  = mk(0, 3'b001, 32'h3002, 0, 32'h80011234, 0, 1, 3,
                2'b00, 4'b1111, 0, 32'h3000, 1, 32'hFFFF8001);
    vt[6]  = mk(0, 3'b101, 32'h3000, 0, 32'h80011234, 0, 1, 3,
                2'b00, 4'b1111, 0, 32'h3000, 1, 32'h00001234);
    vt[7]  = mk(0, 3'b010, 32'h4000, 0, 32'hCAFEF00D, 0, 1, 3,
                2'b00, 4'b1111, 0, 32'h4000, 1, 32'hCAFEF00D);
    vt[8]  = mk(1, 3'b000, 32'h1001, 32'h0000007F, 0, 0, 0, 2,
                2'b00, 4'b0010, 32'h7F7F7F7F, 32'h1000, 1, 32'hCAFEF00D);
    vt[9]  = mk(0, 3'b001, 32'h3001, 0, 0, 0, 0, 1,
                2'b01, 0, 0, 0, 0, 0);
    vt[10] = mk(0, 3'b011, 32'h5000, 0, 0, 0, 0, 1,
                2'b11, 0, 0, 0, 0, 0);
    vt[11] = mk(0, 3'b110, 32'h5001, 0, 0, 0, 0, 1,
                2'b11, 0, 0, 0, 0, 0);
    vt[12] = mk(1, 3'b010, 32'h1002, 32'h11223344, 0, 0, 0, 1,
                2'b01, 0, 0, 0, 0, 0);
    vt[13] = mk(1, 3'b100, 32'h1000, 32'h11223344, 0, 0, 0, 1,
                2'b11, 0, 0, 0, 0, 0);
    vt[14] = mk(0, 3'b010, 32'h7000, 0, 0, 99, 0, 17,
                2'b10, 4'b1111, 0, 32'h7000, 1, 32'h0);

    i_rst_n = 1'b0; i_valid = 1'b0; i_is_store = 1'b0;
    i_funct3 = '0; i_addr = '0; i_wdata = '0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst done", 32'(o_done), 32'd0);
    chk("rst fault", 32'(o_fault), 32'd0);
    chk("rst code", 32'(o_fault_code), 32'd0);
    chk("rst req", 32'(o_mem_req), 32'd0);
    chk("rst we", 32'(o_mem_we), 32'd0);
    chk("rst mask", 32'(o_mem_mask), 32'd0);
    chk("rst rdata", o_rdata, 32'h0);
    chk("rst maddr", o_mem_addr, 32'h0);
    chk("rst mwdata", o_mem_wdata, 32'h0);
    chk("rst busy", 32'(o_busy), 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int k = 0; k < 15; k++) run_vec(vt[k], k);

    // Reload a nonzero value, then reset during WAIT
    run_vec(vt[7], 7);
    chk("pre_rst rdata", o_rdata, 32'hCAFEF00D);
    i_is_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h6000;
    i_mem_rdata = 32'h12345678; i_valid = 1'b1;
    @(posedge i_clk); #1;
    chk("mr req", 32'(o_mem_req), 32'd1);
    i_mem_ready = 1'b1;
    @(posedge i_clk); #1;
    i_mem_ready = 1'b0;
    chk("mr wait_busy", 32'(o_busy), 32'd1);
    chk("mr wait_req", 32'(o_mem_req), 32'd0);
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_mem_rvalid = 1'b1;
    chk("mr req_low", 32'(o_mem_req), 32'd0);
    chk("mr busy", 32'(o_busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      i_mem_rvalid = 1'b0;
      chk($sformatf("mr done%0d", k), 32'(o_done), 32'd0);
      chk($sformatf("mr busy%0d", k), 32'(o_busy), 32'd0);
    end
    chk("mr rdata", o_rdata, 32'h0);
    chk("mr maddr", o_mem_addr, 32'h0);
    chk("mr mask", 32'(o_mem_mask), 32'd0);
    chk("mr code", 32'(o_fault_code), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
